// File: rtl/booth_pkg.sv
// booth_pkg: shared types and width helpers for the sequential radix-4 Booth
// multiplier.
//   state_t         - controller states (IDLE, RUN, DONE)
//   booth_digit_t   - one recoded Booth digit as sign / x2 / x1 flags
//   booth_ext_width - extended operand width E = 2*ceil((WIDTH+1)/2)
//   booth_digits    - number of radix-4 digits D = E/2
//   booth_decode    - 3-bit recoding window -> digit flags
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit value = (sign ? -1 : +1) * (mag2 ? 2 : mag1 ? 1 : 0).
  typedef struct packed {
    logic sign;
    logic mag2;
    logic mag1;
  } booth_digit_t;

  // One extra bit guarantees a sign bit for unsigned operands; rounding up
  // to an even width gives a whole number of radix-4 digits.
  function automatic int booth_ext_width(input int width);
    return 2 * ((width + 2) / 2);
  endfunction

  function automatic int booth_digits(input int width);
    return booth_ext_width(width) / 2;
  endfunction

  // Window {b2,b1,b0} encodes -2*b2 + b1 + b0. 3'b111 is "-0" and is
  // reported as a plain zero so no negation happens for it.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    d.sign = win[2] & ~(win[1] & win[0]);
    d.mag2 = (win == 3'b011) || (win == 3'b100);
    d.mag1 = win[1] ^ win[0];
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: forms one unshifted radix-4 Booth partial product.
//   Parameters: E - extended operand width
//   win_i [2:0]   - recoding window {x[2i+1], x[2i], x[2i-1]}
//   ye_i  [E-1:0] - multiplicand, already sign/zero-extended to E bits
//   pp_o  [2E-1:0]- digit * ye_i, sign-extended to 2E bits
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int E = 26
) (
  input  logic [2:0]     win_i,
  input  logic [E-1:0]   ye_i,
  output logic [2*E-1:0] pp_o
);

  booth_digit_t   dig;
  logic [2*E-1:0] ye_wide;
  logic [2*E-1:0] mag;

  assign dig     = booth_decode(win_i);
  assign ye_wide = {{E{ye_i[E-1]}}, ye_i};

  // NOTE: every output of a combinational block gets a default on entry so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    mag = '0;
    if (dig.mag2) begin
      mag = ye_wide << 1;
    end else if (dig.mag1) begin
      mag = ye_wide;
    end
    pp_o = dig.sign ? -mag : mag;
  end

endmodule

// File: rtl/booth_seq.sv
// booth_seq: iterative radix-4 Booth multiplier, one digit per clock.
//   Parameters: WIDTH - operand width (>= 2)
//   clk, rst           - clock (rising edge), async active-high reset
//   in_valid/in_ready  - operand handshake (x, y, tc)
//   x [WIDTH-1:0]      - multiplier (Booth-recoded)
//   y [WIDTH-1:0]      - multiplicand
//   tc                 - 1: two's-complement operands, 0: unsigned
//   out_valid/out_ready- product handshake
//   p [2*WIDTH-1:0]    - product, held stable while out_valid is high
// Build option: define BOOTH_SEQ_EARLY_TERM_EN to finish as soon as every
// remaining multiplier digit is zero; products are identical either way.
module booth_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int E  = booth_ext_width(WIDTH);
  localparam int D  = booth_digits(WIDTH);
  localparam int CW = $clog2(D + 1);

  state_t          state_q, state_d;
  logic [E-1:0]    xe_q, xe_d;
  logic [E-1:0]    ye_q, ye_d;
  logic [2*E-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [E:0]      xw;       // multiplier with the implicit x[-1]=0 below
  logic [2:0]      win;
  logic [2*E-1:0]  pp;
  logic [2*E-1:0]  pp_sh;
  logic            last_digit;
  logic            rest_zero;

  assign xw         = {xe_q, 1'b0};
  assign win        = 3'(xw >> {cnt_q, 1'b0});
  assign pp_sh      = pp << {cnt_q, 1'b0};
  assign last_digit = (cnt_q == CW'(D - 1));

  booth_pp_gen #(.E(E)) u_pp_gen (
    .win_i (win),
    .ye_i  (ye_q),
    .pp_o  (pp)
  );

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  // Digits above the current one are all zero exactly when the multiplier
  // bits from 2i+1 upward are copies of the top bit.
  always_comb begin
    rest_zero = 1'b1;
    for (int j = 0; j < E; j++) begin
      if ((j > 2 * int'(cnt_q)) && (xe_q[j] != xe_q[E-1])) begin
        rest_zero = 1'b0;
      end
    end
  end
`else
  assign rest_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          xe_d    = {{(E - WIDTH){tc & x[WIDTH-1]}}, x};
          ye_d    = {{(E - WIDTH){tc & y[WIDTH-1]}}, y};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + pp_sh;
        cnt_d = cnt_q + CW'(1);
        if (last_digit || rest_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next state so no input
    // reaches an output combinationally.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      xe_q        <= '0;
      ye_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_seq.sv
// tb_booth_seq: directed and reference-checked bench for booth_seq at
// WIDTH=24. Expected latencies follow BOOTH_SEQ_EARLY_TERM_EN if defined.
module tb_booth_seq;

  localparam int W = 24;
  localparam int TIMEOUT = 100;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           tc;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .tc        (tc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand set; returns #1 after the accepting edge.
  task automatic start(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic tcv);
    @(negedge clk);
    x = xv; y = yv; tc = tcv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check({tag, "_timeout"}, 64'(lat), 64'(TIMEOUT + 1));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ov_after"}, 64'(out_valid), 64'd0);
    check({tag, "_ir_after"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // exp_lat < 0 skips the latency comparison.
  task automatic run(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                     input logic tcv, input logic [2*W-1:0] exp_p, input int exp_lat);
    int lat;
    start(xv, yv, tcv);
    check({tag, "_ir_busy"}, 64'(in_ready), 64'd0);
    wait_done(tag, lat);
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_p"}, 64'(p), 64'(exp_p));
    drain(tag);
  endtask

  initial begin
    int lat;
    int rises;
    logic signed [2*W-1:0] a, b;
    logic [2*W-1:0] ref_p;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; tc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed products with hand-derived latencies.
    run("neg_mult", 24'hFFFFFF, 24'h000003, 1'b1, 48'hFFFFFFFFFFFD, ET ? 1 : 13);
    run("umax",     24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 13);
    run("smin",     24'h800000, 24'h800000, 1'b1, 48'h400000000000, ET ? 12 : 13);
    run("zero",     24'h000000, 24'h123456, 1'b1, 48'h0,            ET ? 1 : 13);
    run("s_mixed",  24'h000007, 24'hFFFFFB, 1'b1, 48'hFFFFFFFFFFDD, ET ? 2 : 13);

    // Backpressure: product and flags hold, stray in_valid ignored.
    start(24'h000002, 24'h000002, 1'b0);
    wait_done("bp", lat);
    check("bp_lat", 64'(lat), ET ? 64'd2 : 64'd13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x = 24'h00ABCD + 24'(i);
      y = 24'h000011;
      @(posedge clk);
      #1;
      check("bp_ov_hold", 64'(out_valid), 64'd1);
      check("bp_p_hold", 64'(p), 64'd4);
      check("bp_ir_low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    @(posedge clk);
    #1;
    check("bp_no_phantom", 64'(out_valid), 64'd0);

    // Reset 6 cycles into RUN abandons the transaction.
    start(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_still_run", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_ir", 64'(in_ready), 64'd1);
    check("mid_rst_p", 64'(p), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    rises = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) rises++;
    end
    check("mid_no_emit", 64'(rises), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    run("after_rst", 24'h000005, 24'h000007, 1'b0, 48'h23, ET ? 2 : 13);

    // Reference sweep against a plain behavioural product.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] xv, yv;
      logic         tv;
      xv = W'($urandom);
      yv = W'($urandom);
      tv = 1'($urandom);
      if (i % 8 == 0) xv = 24'h0000FF & xv;
      a = tv ? {{W{xv[W-1]}}, xv} : {{W{1'b0}}, xv};
      b = tv ? {{W{yv[W-1]}}, yv} : {{W{1'b0}}, yv};
      ref_p = a * b;
      run("rand", xv, yv, tv, ref_p, ET ? -1 : 13);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
